// File: rtl/twiddle_mult_stage.sv
// Complex twiddle multiplier between MDC stages of the 32-point FFT: indices 0..7 bypass, 8..15 multiply by ROM[cnt[2:0]].
// Optional macro TWIDDLE_SAT_EN: clamp the rounded result and add an ovf_flag output; otherwise the result wraps.
module twiddle_mult_stage #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic [2:0]        rom_addr,
  input  logic [TW_W-1:0]   w_r,
  input  logic [TW_W-1:0]   w_i,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im
`ifdef TWIDDLE_SAT_EN
  ,
  output logic              ovf_flag
`endif
);

  localparam int PROD_W = DATA_W + TW_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int SHIFT  = TW_W - 2;
  localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(1 << (SHIFT - 1));

  logic [3:0] frame_cnt;
  logic [3:0] idx;

  // sync forces the current sample to index 0 regardless of the counter
  assign idx      = sync ? 4'd0 : frame_cnt;
  assign rom_addr = frame_cnt[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 4'd0;
    end else if (in_valid) begin
      frame_cnt <= idx + 4'd1;
    end else if (sync) begin
      frame_cnt <= 4'd0;
    end
  end

  // S1: capture sample, twiddle and bypass decision
  logic                     v1, byp1;
  logic signed [DATA_W-1:0] re1, im1;
  logic signed [TW_W-1:0]   wr1, wi1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      byp1 <= 1'b0;
      re1  <= '0;
      im1  <= '0;
      wr1  <= '0;
      wi1  <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        byp1 <= ~idx[3];
        re1  <= in_re;
        im1  <= in_im;
        wr1  <= w_r;
        wi1  <= w_i;
      end
    end
  end

  // S2: partial products plus the delayed bypass data
  logic                     v2, byp2;
  logic signed [DATA_W-1:0] re2, im2;
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      byp2 <= 1'b0;
      re2  <= '0;
      im2  <= '0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        byp2 <= byp1;
        re2  <= re1;
        im2  <= im1;
        p_rr <= PROD_W'(re1) * PROD_W'(wr1);
        p_ii <= PROD_W'(im1) * PROD_W'(wi1);
        p_ri <= PROD_W'(re1) * PROD_W'(wi1);
        p_ir <= PROD_W'(im1) * PROD_W'(wr1);
      end
    end
  end

  // S3: combine, round half up, range-fix
  logic signed [SUM_W-1:0] sum_re, sum_im;
  logic signed [SUM_W-1:0] rnd_re, rnd_im;
  logic [DATA_W-1:0]       fix_re, fix_im;
  logic                    ovf_re, ovf_im;

  assign sum_re = SUM_W'(p_rr) - SUM_W'(p_ii);
  assign sum_im = SUM_W'(p_ri) + SUM_W'(p_ir);
  assign rnd_re = (sum_re + ROUND) >>> SHIFT;
  assign rnd_im = (sum_im + ROUND) >>> SHIFT;

  // Value fits DATA_W when all bits from the DATA_W sign bit upward agree
  assign ovf_re = (rnd_re[SUM_W-1:DATA_W-1] != '0) && (rnd_re[SUM_W-1:DATA_W-1] != '1);
  assign ovf_im = (rnd_im[SUM_W-1:DATA_W-1] != '0) && (rnd_im[SUM_W-1:DATA_W-1] != '1);

`ifdef TWIDDLE_SAT_EN
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  always_comb begin
    fix_re = rnd_re[DATA_W-1:0];
    fix_im = rnd_im[DATA_W-1:0];
    if (ovf_re) fix_re = rnd_re[SUM_W-1] ? MIN_V : MAX_V;
    if (ovf_im) fix_im = rnd_im[SUM_W-1] ? MIN_V : MAX_V;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
    end else begin
      ovf_flag <= v2 & ~byp2 & (ovf_re | ovf_im);
    end
  end
`else
  logic unused_ovf;

  assign fix_re     = rnd_re[DATA_W-1:0];
  assign fix_im     = rnd_im[DATA_W-1:0];
  assign unused_ovf = ovf_re ^ ovf_im;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_re <= byp2 ? re2 : fix_re;
        out_im <= byp2 ? im2 : fix_im;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_mult_stage.sv
// Scoreboard bench for twiddle_mult_stage: arithmetic reference model, randomized gaps/sync, queue-based checking.
module tb_twiddle_mult_stage;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sync = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic [2:0]         rom_addr;
  logic signed [8:0]  w_r, w_i;
  logic               out_valid;
  logic signed [15:0] out_re, out_im;
`ifdef TWIDDLE_SAT_EN
  logic               ovf_flag;
`endif

  twiddle_mult_stage #(.DATA_W(16), .TW_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid),
    .in_re(in_re), .in_im(in_im), .rom_addr(rom_addr), .w_r(w_r), .w_i(w_i),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im)
`ifdef TWIDDLE_SAT_EN
    , .ovf_flag(ovf_flag)
`endif
  );

  always #5 clk = ~clk;

  int rom_r[8];
  int rom_i[8];
  assign w_r = 9'(rom_r[rom_addr]);
  assign w_i = 9'(rom_i[rom_addr]);

  typedef struct {
    longint re;
    longint im;
    bit     ovf;
    longint cyc;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  int     cnt_m = 0;
  longint prev_re = 0, prev_im = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Round half up to Q1.7, then clamp or wrap to 16 bits
  function automatic longint fixv(input longint v, output bit o);
    longint r;
    logic [63:0] b;
    r = (v + 64) >>> 7;
    o = 1'b0;
`ifdef TWIDDLE_SAT_EN
    if (r > 32767) begin
      r = 32767;
      o = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      o = 1'b1;
    end
`else
    b = r;
    r = longint'($signed(b[15:0]));
`endif
    return r;
  endfunction

  task automatic drive(input bit v, input bit s, input longint re, input longint im);
    int idx;
    exp_t e;
    bit o1, o2;
    longint wr, wi;
    @(posedge clk);
    #1;
    in_valid = v;
    sync     = s;
    in_re    = 16'(re);
    in_im    = 16'(im);
    if (v) begin
      idx = s ? 0 : cnt_m;
      chk("rom_addr", rom_addr, cnt_m % 8);
      if (idx < 8) begin
        e.re = re;
        e.im = im;
        e.ovf = 1'b0;
      end else begin
        wr = rom_r[idx % 8];
        wi = rom_i[idx % 8];
        e.re  = fixv(re * wr - im * wi, o1);
        e.im  = fixv(re * wi + im * wr, o2);
        e.ovf = o1 | o2;
      end
      e.cyc = cyc;
      q.push_back(e);
      cnt_m = (idx + 1) % 16;
    end else if (s) begin
      cnt_m = 0;
    end
  endtask

  function automatic longint rnd16();
    return longint'($urandom_range(0, 65535)) - 32768;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b0) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_re", out_re, 0);
      chk("rst_out_im", out_im, 0);
      chk("rst_rom_addr", rom_addr, 0);
      prev_re = 0;
      prev_im = 0;
    end else if (rst_n === 1'b1) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got out_valid=1 expected no pending sample (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("out_re", out_re, e.re);
          chk("out_im", out_im, e.im);
          chk("latency", cyc - e.cyc, 3);
`ifdef TWIDDLE_SAT_EN
          chk("ovf_flag", ovf_flag, e.ovf);
`endif
        end
        prev_re = out_re;
        prev_im = out_im;
      end else begin
        chk("hold_re", out_re, prev_re);
        chk("hold_im", out_im, prev_im);
`ifdef TWIDDLE_SAT_EN
        chk("ovf_idle", ovf_flag, 0);
`endif
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 8; i++) begin
      rom_r[i] = int'($urandom_range(0, 255)) - 128;
      rom_i[i] = int'($urandom_range(0, 255)) - 128;
    end
    rom_r[4] = 0;   rom_i[4] = -128;
    rom_r[2] = 90;  rom_i[2] = -90;
    rom_r[1] = 118; rom_i[1] = -48;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_addr", rom_addr, 0);
    rst_n = 1'b1;
    repeat (4) drive(0, 0, 0, 0);

    for (int k = 0; k < 8; k++) drive(1, k == 0, k, -k);
    for (int k = 8; k < 16; k++) begin
      case (k)
        9:       drive(1, 0, 32767, 32767);
        10:      drive(1, 0, 128, 0);
        12:      drive(1, 0, 100, 50);
        default: drive(1, 0, rnd16(), rnd16());
      endcase
    end

    for (int n = 0; n < 400; n++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rnd16(), rnd16());

    guard = 0;
    while (cnt_m != 5 && guard < 20) begin
      drive(1, 0, rnd16(), rnd16());
      guard++;
    end
    chk("reach_idx5", cnt_m, 5);
    drive(1, 1, rnd16(), rnd16());
    drive(1, 0, rnd16(), rnd16());
    chk("post_sync_addr", rom_addr, 1);

    for (int n = 0; n < 5; n++) drive(1, 0, rnd16(), rnd16());
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    q.delete();
    cnt_m = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) drive(0, 0, 0, 0);
    for (int n = 0; n < 12; n++) drive(1, 0, rnd16(), rnd16());
    drive(0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_queue", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
